// File: rtl/gcn_pkg.sv
// Shared GCN aggregation-path parameters, types and the COO edge scheduler state encoding.
package gcn_pkg;

    localparam int unsigned DOT_PROD_ROWS      = 6;
    localparam int unsigned DOT_PROD_COLS      = 3;
    localparam int unsigned COO_NUM_OF_COLS    = 6;
    localparam int unsigned COO_NUM_OF_ROWS    = 2;
    localparam int unsigned ADJ_DOT_PROD_WIDTH = 16;

    // Width helper that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned COO_BW              = clog2_min1(COO_NUM_OF_COLS);
    localparam int unsigned DOT_PROD_ROWS_WIDTH = clog2_min1(DOT_PROD_ROWS);

    typedef logic [ADJ_DOT_PROD_WIDTH-1:0] fm_wm_row_t [0:DOT_PROD_COLS-1];
    typedef logic [COO_BW-1:0]             coo_col_t   [0:COO_NUM_OF_ROWS-1];

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ROW_REQ    = 3'd1,
        ROW_WAIT   = 3'd2,
        COL_STREAM = 3'd3,
        COL_DRAIN  = 3'd4,
        DONE       = 3'd5
    } sched_state_e;

endpackage

// File: rtl/coo_edge_scheduler.sv
// Walks every FM*WM product row and streams all COO edge columns for it,
// feeding the COO multiplier with row/column strobes and the current row index.
module coo_edge_scheduler #(
    parameter int unsigned  DOT_PROD_ROWS       = gcn_pkg::DOT_PROD_ROWS,
    parameter int unsigned  DOT_PROD_COLS       = gcn_pkg::DOT_PROD_COLS,
    parameter int unsigned  COO_NUM_OF_COLS     = gcn_pkg::COO_NUM_OF_COLS,
    parameter int unsigned  ADJ_DOT_PROD_WIDTH  = gcn_pkg::ADJ_DOT_PROD_WIDTH,
    localparam int unsigned COO_BW              = gcn_pkg::clog2_min1(COO_NUM_OF_COLS),
    localparam int unsigned DOT_PROD_ROWS_WIDTH = gcn_pkg::clog2_min1(DOT_PROD_ROWS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           fm_wm_rd_en,
    output logic [DOT_PROD_ROWS_WIDTH-1:0] fm_wm_addr,
    input  logic [ADJ_DOT_PROD_WIDTH-1:0]  fm_wm_rd_data [0:DOT_PROD_COLS-1],
    output logic                           coo_rd_en,
    output logic [COO_BW-1:0]              coo_addr,
    input  logic [COO_BW-1:0]              coo_rd_data [0:gcn_pkg::COO_NUM_OF_ROWS-1],
    output logic                           is_read_row,
    output logic [ADJ_DOT_PROD_WIDTH-1:0]  FM_WM_Row [0:DOT_PROD_COLS-1],
    output logic                           is_read_column,
    output logic [COO_BW-1:0]              coo_in [0:gcn_pkg::COO_NUM_OF_ROWS-1],
    output logic [DOT_PROD_ROWS_WIDTH-1:0] FM_WM_ROW_Counter
);

    import gcn_pkg::*;

    localparam logic [COO_BW-1:0]              COL_LAST = COO_BW'(COO_NUM_OF_COLS - 1);
    localparam logic [DOT_PROD_ROWS_WIDTH-1:0] ROW_LAST = DOT_PROD_ROWS_WIDTH'(DOT_PROD_ROWS - 1);

    sched_state_e      state_q;
    sched_state_e      state_d;
    logic [COO_BW-1:0] col_cnt_q;
    logic              col_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = ROW_REQ;
            ROW_REQ:    state_d = ROW_WAIT;
            ROW_WAIT:   state_d = COL_STREAM;
            COL_STREAM: if (col_cnt_q == COL_LAST) state_d = COL_DRAIN;
            COL_DRAIN:  state_d = (FM_WM_ROW_Counter == ROW_LAST) ? DONE : ROW_REQ;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            fm_wm_rd_en       <= 1'b0;
            is_read_row       <= 1'b0;
            coo_rd_en         <= 1'b0;
            col_valid_q       <= 1'b0;
            col_cnt_q         <= '0;
            FM_WM_ROW_Counter <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d == ROW_REQ) || (state_d == ROW_WAIT) ||
                           (state_d == COL_STREAM) || (state_d == COL_DRAIN);
            done        <= (state_d == DONE);
            fm_wm_rd_en <= (state_d == ROW_REQ);
            is_read_row <= (state_d == ROW_WAIT);
            coo_rd_en   <= (state_d == COL_STREAM);
            col_valid_q <= coo_rd_en;

            if (state_d == ROW_REQ)
                col_cnt_q <= '0;
            else if ((state_q == COL_STREAM) && (col_cnt_q != COL_LAST))
                col_cnt_q <= col_cnt_q + 1'b1;

            if (state_q == DONE)
                FM_WM_ROW_Counter <= '0;
            else if ((state_q == COL_DRAIN) && (state_d == ROW_REQ))
                FM_WM_ROW_Counter <= FM_WM_ROW_Counter + 1'b1;
        end
    end

    assign fm_wm_addr = FM_WM_ROW_Counter;
    assign coo_addr   = col_cnt_q;
    assign FM_WM_Row  = fm_wm_rd_data;
    assign coo_in     = coo_rd_data;

    // A zero node id marks a padding edge: data still flows but is not strobed.
    assign is_read_column = col_valid_q && (coo_rd_data[0] != '0) && (coo_rd_data[1] != '0);

endmodule

// File: tb/tb_coo_edge_scheduler.sv
// Directed bench for coo_edge_scheduler: default instance plus a 1-row / 2-column corner instance.
module tb_coo_edge_scheduler;
    import gcn_pkg::*;

    localparam int TR = 70;

    typedef struct {
        int cyc;
        bit rr;
        bit rc;
        bit dn;
        bit bz;
        bit fe;
        int cnt;
    } vec_t;

    logic clk, reset, start, padding;
    int   edge_cnt = 0;
    int   t0 = 0;
    bit   rec_en = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs [14];

    logic                           busy, done, fm_wm_rd_en, coo_rd_en, is_read_row, is_read_column;
    logic [DOT_PROD_ROWS_WIDTH-1:0] fm_wm_addr, row_cnt;
    logic [COO_BW-1:0]              coo_addr;
    fm_wm_row_t                     fm_rd, row_out;
    coo_col_t                       coo_rd, coo_out;

    logic        c_busy, c_done, c_fe, c_ce, c_rr, c_rc;
    logic [0:0]  c_fa, c_ca, c_cnt;
    logic [15:0] c_fm_rd [0:2];
    logic [15:0] c_row_out [0:2];
    logic [0:0]  c_coo_rd [0:1];
    logic [0:0]  c_coo_out [0:1];

    coo_edge_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .fm_wm_rd_en(fm_wm_rd_en), .fm_wm_addr(fm_wm_addr), .fm_wm_rd_data(fm_rd),
        .coo_rd_en(coo_rd_en), .coo_addr(coo_addr), .coo_rd_data(coo_rd),
        .is_read_row(is_read_row), .FM_WM_Row(row_out), .is_read_column(is_read_column),
        .coo_in(coo_out), .FM_WM_ROW_Counter(row_cnt)
    );

    coo_edge_scheduler #(.DOT_PROD_ROWS(1), .COO_NUM_OF_COLS(2)) dut_corner (
        .clk(clk), .reset(reset), .start(start), .busy(c_busy), .done(c_done),
        .fm_wm_rd_en(c_fe), .fm_wm_addr(c_fa), .fm_wm_rd_data(c_fm_rd),
        .coo_rd_en(c_ce), .coo_addr(c_ca), .coo_rd_data(c_coo_rd),
        .is_read_row(c_rr), .FM_WM_Row(c_row_out), .is_read_column(c_rc),
        .coo_in(c_coo_out), .FM_WM_ROW_Counter(c_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int coo_src(input int c);
        if (padding && c == 3) return 0;
        return c + 1;
    endfunction

    function automatic int coo_dst(input int c);
        if (padding && c == 3) return 2;
        return ((c + 1) % 6) + 1;
    endfunction

    // Synchronous-read memory models, one cycle latency
    always @(posedge clk) begin
        if (fm_wm_rd_en)
            for (int i = 0; i < 3; i++) fm_rd[i] <= 16'(int'(fm_wm_addr) * 10 + i);
        if (coo_rd_en) begin
            coo_rd[0] <= 3'(coo_src(int'(coo_addr)));
            coo_rd[1] <= 3'(coo_dst(int'(coo_addr)));
        end
        if (c_fe)
            for (int i = 0; i < 3; i++) c_fm_rd[i] <= 16'(100 + i);
        if (c_ce) begin
            c_coo_rd[0] <= 1'b1;
            c_coo_rd[1] <= 1'b1;
        end
    end

    bit rr_t [TR], rc_t [TR], dn_t [TR], bz_t [TR], fe_t [TR], ce_t [TR];
    bit crr_t [TR], crc_t [TR], cdn_t [TR];
    int cnt_t [TR], fa_t [TR], ca_t [TR], src_t [TR], dst_t [TR];
    int fmd_t [TR][3];

    always @(negedge clk) begin
        int k;
        k = edge_cnt - t0;
        if (rec_en && k >= 0 && k < TR) begin
            rr_t[k]  = is_read_row;
            rc_t[k]  = is_read_column;
            dn_t[k]  = done;
            bz_t[k]  = busy;
            fe_t[k]  = fm_wm_rd_en;
            ce_t[k]  = coo_rd_en;
            cnt_t[k] = int'(row_cnt);
            fa_t[k]  = int'(fm_wm_addr);
            ca_t[k]  = int'(coo_addr);
            src_t[k] = int'(coo_out[0]);
            dst_t[k] = int'(coo_out[1]);
            for (int j = 0; j < 3; j++) fmd_t[k][j] = int'(row_out[j]);
            crr_t[k] = c_rr;
            crc_t[k] = c_rc;
            cdn_t[k] = c_done;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start high for `hold` cycles beginning at cycle 0, then record up to cycle TR-1.
    task automatic launch(input int hold);
        @(posedge clk);
        #1;
        t0     = edge_cnt;
        rec_en = 1;
        start  = 1;
        repeat (hold) @(posedge clk);
        #1 start = 0;
        repeat (TR - hold) @(posedge clk);
        #1 rec_en = 0;
    endtask

    function automatic bit exp_rr(input int k);
        return k >= 2 && k <= 47 && (k - 2) % 9 == 0;
    endfunction
    function automatic bit exp_fe(input int k);
        return k >= 1 && k <= 46 && (k - 1) % 9 == 0;
    endfunction
    function automatic bit exp_ce(input int k);
        return k >= 3 && k <= 53 && (k - 3) % 9 < 6;
    endfunction
    function automatic bit exp_rc(input int k, input bit pad);
        return k >= 4 && k <= 54 && (k - 4) % 9 < 6 && !(pad && (k - 4) % 9 == 3);
    endfunction
    function automatic int exp_cnt(input int k);
        if (k < 1 || k > 55) return 0;
        return ((k - 1) / 9 > 5) ? 5 : (k - 1) / 9;
    endfunction

    task automatic check_pass(input string tag, input bit pad);
        int bad_rr, bad_rc, bad_dn, bad_bz, bad_fe, bad_ce, bad_cnt, bad_ca, bad_fa;
        int n_rr, n_rc, n_dn;
        int acc [6], gold [6], row_buf [3];
        bad_rr = 0; bad_rc = 0; bad_dn = 0; bad_bz = 0; bad_fe = 0;
        bad_ce = 0; bad_cnt = 0; bad_ca = 0; bad_fa = 0;
        n_rr = 0; n_rc = 0; n_dn = 0;
        for (int k = 0; k < TR; k++) begin
            if (rr_t[k] != exp_rr(k)) bad_rr++;
            if (rc_t[k] != exp_rc(k, pad)) bad_rc++;
            if (dn_t[k] != (k == 55)) bad_dn++;
            if (bz_t[k] != (k >= 1 && k <= 54)) bad_bz++;
            if (fe_t[k] != exp_fe(k)) bad_fe++;
            if (ce_t[k] != exp_ce(k)) bad_ce++;
            if (cnt_t[k] != exp_cnt(k)) bad_cnt++;
            if (exp_ce(k) && ca_t[k] != (k - 3) % 9) bad_ca++;
            if (exp_fe(k) && fa_t[k] != (k - 1) / 9) bad_fa++;
            n_rr += int'(rr_t[k]);
            n_rc += int'(rc_t[k]);
            n_dn += int'(dn_t[k]);
        end
        check({tag, " rr_pattern_bad_cycles"}, bad_rr, 0);
        check({tag, " rc_pattern_bad_cycles"}, bad_rc, 0);
        check({tag, " done_pattern_bad_cycles"}, bad_dn, 0);
        check({tag, " busy_pattern_bad_cycles"}, bad_bz, 0);
        check({tag, " fm_rd_en_pattern_bad_cycles"}, bad_fe, 0);
        check({tag, " coo_rd_en_pattern_bad_cycles"}, bad_ce, 0);
        check({tag, " row_counter_bad_cycles"}, bad_cnt, 0);
        check({tag, " coo_addr_bad_cycles"}, bad_ca, 0);
        check({tag, " fm_addr_bad_cycles"}, bad_fa, 0);
        check({tag, " is_read_row_count"}, n_rr, 6);
        check({tag, " is_read_column_count"}, n_rc, pad ? 30 : 36);
        check({tag, " done_count"}, n_dn, 1);

        for (int v = 0; v < 14; v++) begin
            int c;
            c = vecs[v].cyc;
            check($sformatf("%s vec%0d flags@%0d", tag, v, c),
                  int'({rr_t[c], rc_t[c], dn_t[c], bz_t[c], fe_t[c]}),
                  int'({vecs[v].rr, vecs[v].rc, vecs[v].dn, vecs[v].bz, vecs[v].fe}));
            check($sformatf("%s vec%0d row_cnt@%0d", tag, v, c), cnt_t[c], vecs[v].cnt);
        end

        for (int k = 0; k < TR; k++) begin
            if (exp_rr(k) && rr_t[k])
                for (int j = 0; j < 3; j++)
                    check($sformatf("%s FM_WM_Row[%0d]@%0d", tag, j, k), fmd_t[k][j], ((k - 2) / 9) * 10 + j);
            if (exp_rc(k, pad) && rc_t[k]) begin
                check($sformatf("%s coo_src@%0d", tag, k), src_t[k], coo_src((k - 4) % 9));
                check($sformatf("%s coo_dst@%0d", tag, k), dst_t[k], coo_dst((k - 4) % 9));
            end
        end

        // Multiplier-style accumulation: edge src==row+1 adds that row into dst
        for (int d = 0; d < 6; d++) begin acc[d] = 0; gold[d] = 0; end
        for (int j = 0; j < 3; j++) row_buf[j] = 0;
        for (int k = 0; k < TR; k++) begin
            if (rr_t[k]) for (int j = 0; j < 3; j++) row_buf[j] = fmd_t[k][j];
            if (rc_t[k] && src_t[k] - 1 == cnt_t[k] && dst_t[k] >= 1 && dst_t[k] <= 6)
                for (int j = 0; j < 3; j++) acc[dst_t[k] - 1] += row_buf[j];
        end
        for (int c = 0; c < 6; c++)
            if (coo_src(c) != 0)
                for (int j = 0; j < 3; j++) gold[coo_dst(c) - 1] += (coo_src(c) - 1) * 10 + j;
        for (int d = 0; d < 6; d++)
            check($sformatf("%s aggregate_node%0d", tag, d + 1), acc[d], gold[d]);
    endtask

    initial begin
        int bad, n, found_k;
        vecs[0]  = '{0,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,  0, 0, 0, 1, 1, 0};
        vecs[2]  = '{2,  1, 0, 0, 1, 0, 0};
        vecs[3]  = '{3,  0, 0, 0, 1, 0, 0};
        vecs[4]  = '{4,  0, 1, 0, 1, 0, 0};
        vecs[5]  = '{9,  0, 1, 0, 1, 0, 0};
        vecs[6]  = '{10, 0, 0, 0, 1, 1, 1};
        vecs[7]  = '{11, 1, 0, 0, 1, 0, 1};
        vecs[8]  = '{13, 0, 1, 0, 1, 0, 1};
        vecs[9]  = '{46, 0, 0, 0, 1, 1, 5};
        vecs[10] = '{53, 0, 1, 0, 1, 0, 5};
        vecs[11] = '{54, 0, 1, 0, 1, 0, 5};
        vecs[12] = '{55, 0, 0, 1, 0, 0, 5};
        vecs[13] = '{56, 0, 0, 0, 0, 0, 0};

        reset = 1; start = 0; padding = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset rd_enables", int'({fm_wm_rd_en, coo_rd_en}), 0);
        check("reset strobes", int'({is_read_row, is_read_column}), 0);
        check("reset row_counter", int'(row_cnt), 0);
        reset = 0;
        repeat (2) @(posedge clk);

        // Full pass, defaults
        launch(1);
        check_pass("pass", 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (crr_t[k] != (k == 2)) bad++;
            if (crc_t[k] != (k == 4 || k == 5)) bad++;
            if (cdn_t[k] != (k == 6)) bad++;
        end
        check("corner pattern_bad_cycles", bad, 0);
        check("corner done@6", int'(cdn_t[6]), 1);
        check("corner is_read_column@4,5", int'({crc_t[4], crc_t[5]}), 3);

        // Padding edge in column 3
        padding = 1;
        launch(1);
        check_pass("pad", 1);
        n = 0;
        for (int r = 0; r < 6; r++) n += int'(rc_t[7 + 9 * r]);
        check("pad column3_strobes", n, 0);
        padding = 0;

        // start held for 60 cycles: one pass, re-accepted only after IDLE returns
        launch(60);
        check("held done@55", int'(dn_t[55]), 1);
        check("held no_restart_on_done fm_rd_en@56", int'(fe_t[56]), 0);
        check("held busy@56", int'(bz_t[56]), 0);
        check("held restart fm_rd_en@57", int'(fe_t[57]), 1);
        check("held busy@57", int'(bz_t[57]), 1);
        n = 0;
        for (int k = 0; k <= 56; k++) n += int'(rr_t[k]);
        check("held is_read_row_count_first_pass", n, 6);
        found_k = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                found_k = edge_cnt - t0;
                break;
            end
        end
        check("held second_pass_done_cycle", found_k, 111);

        // Reset asserted while row 2 is streaming
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (21) @(posedge clk);
        #1;
        check("midpass coo_rd_en@22", int'(coo_rd_en), 1);
        check("midpass row_counter@22", int'(row_cnt), 2);
        #2 reset = 1;
        #1;
        check("async_reset outputs", int'({busy, done, fm_wm_rd_en, coo_rd_en, is_read_row, is_read_column}), 0);
        check("async_reset counters", int'({row_cnt, coo_addr}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n += int'(done) + int'(busy);
        end
        check("after_reset no_done_no_busy", n, 0);
        launch(1);
        check_pass("rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
